// File: rtl/frame_composer.sv
// frame_composer: walks the framebuffer in raster order and writes one pixel
// per fixed-length slot. Compose layers keyed sprites over a scrolled map,
// fade darkens the existing frame, fill paints a constant colour.
// Read addresses are registered. They are computed from next-cycle counter
// values, so each address is on its port during the phase that issues it.
module frame_composer #(
    parameter int          FB_W      = 240,
    parameter int          FB_H      = 160,
    parameter int          MAP_W     = 464,
    parameter int          MAP_H     = 388,
    parameter int          NUM_SPR   = 2,
    parameter int          SPR_W     = 16,
    parameter int          SPR_H     = 21,
    parameter int          SHEET_W   = 271,
    parameter logic [23:0] KEY       = 24'hFF00FF,
    parameter int          FADE_STEP = 5,
    parameter int          ADDR_W    = 19
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [23:0]               fill_color,
    input  logic [9:0]                cam_x,
    input  logic [9:0]                cam_y,
    input  logic [NUM_SPR-1:0]        spr_en,
    input  logic [NUM_SPR-1:0]        spr_mirror,
    input  logic [NUM_SPR*10-1:0]     spr_x,
    input  logic [NUM_SPR*10-1:0]     spr_y,
    input  logic [NUM_SPR*ADDR_W-1:0] spr_base,
    output logic [ADDR_W-1:0]         map_addr,
    input  logic [23:0]               map_data,
    output logic [ADDR_W-1:0]         spr_addr,
    input  logic [23:0]               spr_data,
    output logic [ADDR_W-1:0]         fb_raddr,
    input  logic [23:0]               fb_rdata,
    output logic                      fb_we,
    output logic [ADDR_W-1:0]         fb_waddr,
    output logic [23:0]               fb_wdata,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the final phase of a pixel slot for a given mode.
    function automatic logic [3:0] last_phase(input logic [1:0] m);
        logic [3:0] lp;
        case (m)
            2'd0:    lp = 4'(NUM_SPR + 1);
            2'd1:    lp = 4'd1;
            default: lp = 4'd0;
        endcase
        return lp;
    endfunction

    // One colour channel stepped toward black, clamped at zero.
    function automatic logic [7:0] fade_ch(input logic [7:0] c);
        return (c < 8'(FADE_STEP)) ? 8'd0 : c - 8'(FADE_STEP);
    endfunction

    state_t                    state_r, state_n;
    logic [9:0]                x_r, y_r, x_n, y_n;
    logic [3:0]                ph_r, ph_n;
    logic [ADDR_W-1:0]         pix_r, pix_n;

    logic [1:0]                mode_r;
    logic [23:0]               fill_r;
    logic [9:0]                cam_x_r, cam_y_r;
    logic [NUM_SPR-1:0]        en_r, mir_r;
    logic [NUM_SPR*10-1:0]     sx_r, sy_r;
    logic [NUM_SPR*ADDR_W-1:0] base_r;

    logic [ADDR_W-1:0]         map_addr_r, spr_addr_r, fb_raddr_r, fb_waddr_r;
    logic [23:0]               fb_wdata_r, acc_r;
    logic                      fb_we_r, busy_r, done_r;
    logic                      oob_r, spr_hit_r, spr_hit_d_r;

    logic                      accept_s, run_n_s, map_rd_s, fade_rd_s, spr_slot_s;
    logic                      oob_s, hit_s, write_s;
    logic [1:0]                mode_s;
    logic [9:0]                cam_x_s, cam_y_s;
    logic [10:0]               mx_s, my_s, dx_s, dy_s, col_s;
    logic [9:0]                sel_x_s, sel_y_s;
    logic                      sel_en_s, sel_mir_s;
    logic [ADDR_W-1:0]         sel_base_s, map_lin_s, spr_lin_s;
    logic [ADDR_W-1:0]         map_addr_n_s, spr_addr_n_s, fb_raddr_n_s;
    logic [23:0]               cur_s, wdata_s;

    assign map_addr = map_addr_r;
    assign spr_addr = spr_addr_r;
    assign fb_raddr = fb_raddr_r;
    assign fb_we    = fb_we_r;
    assign fb_waddr = fb_waddr_r;
    assign fb_wdata = fb_wdata_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Next-state and raster/phase counter advance.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && !done_r && start;
        state_n  = state_r;
        x_n      = x_r;
        y_n      = y_r;
        ph_n     = ph_r;
        pix_n    = pix_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n = ST_RUN;
                    x_n     = 10'd0;
                    y_n     = 10'd0;
                    ph_n    = 4'd0;
                    pix_n   = {ADDR_W{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ph_r == last_phase(mode_r)) begin
                    ph_n  = 4'd0;
                    pix_n = pix_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (x_r == 10'(FB_W - 1)) begin
                        x_n = 10'd0;
                        if (y_r == 10'(FB_H - 1)) begin
                            state_n = ST_DONE;
                            y_n     = 10'd0;
                            pix_n   = {ADDR_W{1'b0}};
                        end else begin
                            y_n = y_r + 10'd1;
                        end
                    end else begin
                        x_n = x_r + 10'd1;
                    end
                end else begin
                    ph_n = ph_r + 4'd1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Read addresses for the phase that starts on the next edge.
    always_comb begin
        mode_s   = accept_s ? mode  : mode_r;
        cam_x_s  = accept_s ? cam_x : cam_x_r;
        cam_y_s  = accept_s ? cam_y : cam_y_r;
        run_n_s  = (state_n == ST_RUN);
        map_rd_s  = run_n_s && (mode_s == 2'd0) && (ph_n == 4'd0);
        fade_rd_s = run_n_s && (mode_s == 2'd1) && (ph_n == 4'd0);
        spr_slot_s = run_n_s && (mode_s == 2'd0) && (ph_n >= 4'd1) &&
                     (ph_n <= 4'(NUM_SPR));

        mx_s      = {1'b0, cam_x_s} + {1'b0, x_n};
        my_s      = {1'b0, cam_y_s} + {1'b0, y_n};
        oob_s     = (mx_s >= 11'(MAP_W)) || (my_s >= 11'(MAP_H));
        map_lin_s = ADDR_W'(my_s) * ADDR_W'(MAP_W) + ADDR_W'(mx_s);
        map_addr_n_s = (map_rd_s && !oob_s) ? map_lin_s : {ADDR_W{1'b0}};

        // Slot s is read in phase s+1.
        sel_x_s    = 10'd0;
        sel_y_s    = 10'd0;
        sel_en_s   = 1'b0;
        sel_mir_s  = 1'b0;
        sel_base_s = {ADDR_W{1'b0}};
        for (int s = 0; s < NUM_SPR; s++) begin
            sel_x_s    = (ph_n == 4'(s + 1)) ? sx_r[s*10 +: 10]           : sel_x_s;
            sel_y_s    = (ph_n == 4'(s + 1)) ? sy_r[s*10 +: 10]           : sel_y_s;
            sel_en_s   = (ph_n == 4'(s + 1)) ? en_r[s]                    : sel_en_s;
            sel_mir_s  = (ph_n == 4'(s + 1)) ? mir_r[s]                   : sel_mir_s;
            sel_base_s = (ph_n == 4'(s + 1)) ? base_r[s*ADDR_W +: ADDR_W] : sel_base_s;
        end

        // Unsigned 11-bit differences: a pixel left of or above the sprite wraps large and misses.
        dx_s  = {1'b0, x_n} - {1'b0, sel_x_s};
        dy_s  = {1'b0, y_n} - {1'b0, sel_y_s};
        hit_s = spr_slot_s && sel_en_s && (dx_s < 11'(SPR_W)) && (dy_s < 11'(SPR_H));
        col_s = sel_mir_s ? (11'(SPR_W - 1) - dx_s) : dx_s;
        spr_lin_s = sel_base_s + ADDR_W'(dy_s) * ADDR_W'(SHEET_W) + ADDR_W'(col_s);
        spr_addr_n_s = hit_s ? spr_lin_s : {ADDR_W{1'b0}};

        fb_raddr_n_s = fade_rd_s ? pix_n : {ADDR_W{1'b0}};
    end

    // Layer the data returned this cycle and pick the value to write.
    always_comb begin
        cur_s = acc_r;
        if (ph_r == 4'd1) begin
            cur_s = oob_r ? 24'd0 : map_data;
        end else if ((ph_r >= 4'd2) && spr_hit_d_r && (spr_data != KEY)) begin
            cur_s = spr_data;
        end else begin
            cur_s = acc_r;
        end
        write_s = (state_r == ST_RUN) && (ph_r == last_phase(mode_r));
        case (mode_r)
            2'd0:    wdata_s = cur_s;
            2'd1:    wdata_s = {fade_ch(fb_rdata[23:16]), fade_ch(fb_rdata[15:8]),
                                fade_ch(fb_rdata[7:0])};
            default: wdata_s = fill_r;
        endcase
    end

    // State and raster counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
            x_r     <= 10'd0;
            y_r     <= 10'd0;
            ph_r    <= 4'd0;
            pix_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_n;
            x_r     <= x_n;
            y_r     <= y_n;
            ph_r    <= ph_n;
            pix_r   <= pix_n;
        end
    end

    // Frame snapshot of all configuration inputs, taken when a pass is accepted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_r  <= 2'd0;
            fill_r  <= 24'd0;
            cam_x_r <= 10'd0;
            cam_y_r <= 10'd0;
            en_r    <= {NUM_SPR{1'b0}};
            mir_r   <= {NUM_SPR{1'b0}};
            sx_r    <= {(NUM_SPR*10){1'b0}};
            sy_r    <= {(NUM_SPR*10){1'b0}};
            base_r  <= {(NUM_SPR*ADDR_W){1'b0}};
        end else if (accept_s) begin
            mode_r  <= mode;
            fill_r  <= fill_color;
            cam_x_r <= cam_x;
            cam_y_r <= cam_y;
            en_r    <= spr_en;
            mir_r   <= spr_mirror;
            sx_r    <= spr_x;
            sy_r    <= spr_y;
            base_r  <= spr_base;
        end
    end

    // Registered read ports and the hit/out-of-bounds tags that travel with each read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            map_addr_r  <= {ADDR_W{1'b0}};
            spr_addr_r  <= {ADDR_W{1'b0}};
            fb_raddr_r  <= {ADDR_W{1'b0}};
            oob_r       <= 1'b0;
            spr_hit_r   <= 1'b0;
            spr_hit_d_r <= 1'b0;
        end else begin
            map_addr_r  <= map_addr_n_s;
            spr_addr_r  <= spr_addr_n_s;
            fb_raddr_r  <= fb_raddr_n_s;
            oob_r       <= map_rd_s ? oob_s : oob_r;
            spr_hit_r   <= hit_s;
            spr_hit_d_r <= spr_hit_r;
        end
    end

    // Pixel accumulator and framebuffer write port.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_r      <= 24'd0;
            fb_we_r    <= 1'b0;
            fb_waddr_r <= {ADDR_W{1'b0}};
            fb_wdata_r <= 24'd0;
        end else begin
            acc_r      <= (state_r == ST_RUN) ? cur_s : acc_r;
            fb_we_r    <= write_s;
            fb_waddr_r <= write_s ? pix_r : {ADDR_W{1'b0}};
            fb_wdata_r <= write_s ? wdata_s : 24'd0;
        end
    end

    // Busy spans the pass; done pulses as busy drops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (state_r == ST_DONE) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            done_r <= (state_r == ST_DONE);
        end
    end

endmodule

// File: tb/tb_frame_composer.sv
// Bench for frame_composer: RAM models, an expected-write queue filled from a
// reference model at each start, and directed timing/port checks.
module tb_frame_composer;

    localparam int          FB_W      = 180;
    localparam int          FB_H      = 12;
    localparam int          NPIX      = FB_W * FB_H;
    localparam int          MAP_W     = 464;
    localparam int          MAP_H     = 388;
    localparam int          NUM_SPR   = 2;
    localparam int          SPR_W     = 16;
    localparam int          SPR_H     = 21;
    localparam int          SHEET_W   = 271;
    localparam logic [23:0] KEY       = 24'hFF00FF;
    localparam int          FADE_STEP = 5;
    localparam int          ADDR_W    = 19;

    logic                      Clk        = 1'b0;
    logic                      Reset_n    = 1'b0;
    logic                      start      = 1'b0;
    logic [1:0]                mode       = 2'd0;
    logic [23:0]               fill_color = 24'd0;
    logic [9:0]                cam_x      = 10'd0;
    logic [9:0]                cam_y      = 10'd0;
    logic [NUM_SPR-1:0]        spr_en     = '0;
    logic [NUM_SPR-1:0]        spr_mirror = '0;
    logic [NUM_SPR*10-1:0]     spr_x      = '0;
    logic [NUM_SPR*10-1:0]     spr_y      = '0;
    logic [NUM_SPR*ADDR_W-1:0] spr_base   = '0;
    logic [ADDR_W-1:0]         map_addr, spr_addr, fb_raddr, fb_waddr;
    logic [23:0]               map_data = 24'd0, spr_data = 24'd0, fb_rdata = 24'd0;
    logic [23:0]               fb_wdata;
    logic                      fb_we, busy, done;

    typedef struct {
        int          addr;
        logic [23:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;
    int  n_total   = 0;
    int  n_pass    = 0;
    int  wr_cnt    = 0;
    int  cyc       = 0;
    int  start_cyc = 0;
    int  first_lat = -1;
    int  wr_snap   = 0;

    frame_composer #(
        .FB_W(FB_W), .FB_H(FB_H), .MAP_W(MAP_W), .MAP_H(MAP_H), .NUM_SPR(NUM_SPR),
        .SPR_W(SPR_W), .SPR_H(SPR_H), .SHEET_W(SHEET_W), .KEY(KEY),
        .FADE_STEP(FADE_STEP), .ADDR_W(ADDR_W)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .mode(mode),
        .fill_color(fill_color), .cam_x(cam_x), .cam_y(cam_y),
        .spr_en(spr_en), .spr_mirror(spr_mirror), .spr_x(spr_x), .spr_y(spr_y),
        .spr_base(spr_base), .map_addr(map_addr), .map_data(map_data),
        .spr_addr(spr_addr), .spr_data(spr_data), .fb_raddr(fb_raddr),
        .fb_rdata(fb_rdata), .fb_we(fb_we), .fb_waddr(fb_waddr),
        .fb_wdata(fb_wdata), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [23:0] map_fn(input logic [ADDR_W-1:0] a);
        return 24'(a);
    endfunction

    function automatic logic [23:0] sheet_fn(input logic [ADDR_W-1:0] a);
        return (a[2:0] == 3'd5) ? KEY : {4'hA, 1'b0, a};
    endfunction

    function automatic logic [23:0] fb_fn(input logic [ADDR_W-1:0] a);
        return (a == 19'd5) ? 24'h04FF06 : {a[7:0], a[7:0] ^ 8'hA3, a[10:3]};
    endfunction

    function automatic logic [7:0] fade_ch(input logic [7:0] c);
        return (int'(c) < FADE_STEP) ? 8'd0 : 8'(int'(c) - FADE_STEP);
    endfunction

    // Synchronous-read RAM models, one cycle of latency.
    always @(posedge Clk) begin
        map_data <= map_fn(map_addr);
        spr_data <= sheet_fn(spr_addr);
        fb_rdata <= fb_fn(fb_raddr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference pixel for compose mode from the current input settings.
    function automatic logic [23:0] exp_compose(input int x, input int y);
        int mx, my, col, row, c;
        logic [23:0] acc, d;
        logic [ADDR_W-1:0] a;
        mx = int'(cam_x) + x;
        my = int'(cam_y) + y;
        if (mx >= MAP_W || my >= MAP_H) acc = 24'd0;
        else acc = map_fn(ADDR_W'(my * MAP_W + mx));
        for (int s = 0; s < NUM_SPR; s++) begin
            col = x - int'(spr_x[s*10 +: 10]);
            row = y - int'(spr_y[s*10 +: 10]);
            if (spr_en[s] && col >= 0 && col < SPR_W && row >= 0 && row < SPR_H) begin
                c = spr_mirror[s] ? (SPR_W - 1 - col) : col;
                a = ADDR_W'(int'(spr_base[s*ADDR_W +: ADDR_W]) + row * SHEET_W + c);
                d = sheet_fn(a);
                if (d != KEY) acc = d;
            end
        end
        return acc;
    endfunction

    task automatic push_pass(input int m);
        for (int i = 0; i < NPIX; i++) begin
            wr_t w;
            logic [23:0] r;
            w.addr = i;
            r = fb_fn(ADDR_W'(i));
            case (m)
                0:       w.data = exp_compose(i % FB_W, i / FB_W);
                1:       w.data = (i == 5) ? 24'h00FA01
                                           : {fade_ch(r[23:16]), fade_ch(r[15:8]), fade_ch(r[7:0])};
                default: w.data = fill_color;
            endcase
            exp_q.push_back(w);
        end
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        wr_cnt    = 0;
        first_lat = -1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge Clk);
            #1;
            if (done === 1'b1) break;
        end
    endtask

    task automatic finish_pass(input int p);
        wait_done(NPIX * p + 20);
        chk("done_latency", 32'(cyc - start_cyc), 32'(NPIX * p + 1));
        chk("busy_fall", 32'(busy), 32'd0);
        chk("first_write_latency", 32'(first_lat), 32'(p));
        chk("write_count", 32'(wr_cnt), 32'(NPIX));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_pass(input int p);
        push_pass(int'(mode));
        pulse_start();
        chk("busy_rise", 32'(busy), 32'd1);
        finish_pass(p);
        @(posedge Clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    // Scoreboard side: every framebuffer write pops one expected write.
    always @(negedge Clk) begin
        if (fb_we === 1'b1) begin
            if (wr_cnt == 0) first_lat = cyc - start_cyc;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(fb_we), 32'd0);
            end else begin
                mon_w = exp_q.pop_front();
                chk("wr_addr", 32'(fb_waddr), 32'(mon_w.addr));
                chk("wr_data", 32'(fb_wdata), 32'(mon_w.data));
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_map_addr", 32'(map_addr), 32'd0);
        chk("rst_spr_addr", 32'(spr_addr), 32'd0);
        chk("rst_fb_raddr", 32'(fb_raddr), 32'd0);
        chk("rst_fb_waddr", 32'(fb_waddr), 32'd0);
        chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        // Fill
        mode = 2'd2;
        fill_color = 24'h123456;
        run_pass(1);

        // Compose, map only, with a start pulse mid-pass and one coincident with done
        mode = 2'd0;
        cam_x = 10'd0;
        cam_y = 10'd0;
        spr_en = 2'b00;
        push_pass(0);
        pulse_start();
        chk("busy_rise_compose", 32'(busy), 32'd1);
        repeat ((3 * FB_W + 5) * 4) @(posedge Clk);
        #1;
        chk("map_addr_px_5_3", 32'(map_addr), 32'(3 * MAP_W + 5));
        @(negedge Clk);
        start = 1'b1;
        mode = 2'd2;
        fill_color = 24'hDEAD00;
        @(posedge Clk);
        #1;
        start = 1'b0;
        chk("busy_after_restart_attempt", 32'(busy), 32'd1);
        finish_pass(4);
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        chk("start_at_done_ignored", 32'(busy), 32'd0);
        chk("done_one_cycle_compose", 32'(done), 32'd0);
        repeat (10) @(posedge Clk);

        // Compose, map bounds
        mode = 2'd0;
        cam_x = 10'd300;
        cam_y = 10'd380;
        run_pass(4);

        // Compose with two overlapping sprites, slot0 mirrored
        cam_x = 10'd7;
        cam_y = 10'd2;
        spr_en = 2'b11;
        spr_mirror = 2'b01;
        spr_x = {10'd12, 10'd10};
        spr_y = {10'd10, 10'd10};
        spr_base = {19'd5000, 19'd100};
        push_pass(0);
        pulse_start();
        repeat ((10 * FB_W + 10) * 4 + 1) @(posedge Clk);
        #1;
        chk("spr_addr_mirror_col0", 32'(spr_addr), 32'd115);
        @(posedge Clk);
        #1;
        chk("spr_addr_slot1_miss", 32'(spr_addr), 32'd0);
        repeat (12) @(posedge Clk);
        #1;
        chk("spr_addr_slot1_hit_13_10", 32'(spr_addr), 32'd5001);
        finish_pass(4);
        repeat (3) @(posedge Clk);

        // Fade
        mode = 2'd1;
        spr_en = 2'b00;
        run_pass(2);

        // Reserved mode behaves as fill
        mode = 2'd3;
        fill_color = 24'hABCDEF;
        run_pass(1);

        // Reset in the middle of a pass
        mode = 2'd2;
        fill_color = 24'h0F0F0F;
        push_pass(2);
        pulse_start();
        repeat (100) @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("midrst_fb_we", 32'(fb_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        wr_snap = wr_cnt;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (60) @(posedge Clk);
        #1;
        chk("post_reset_writes", 32'(wr_cnt - wr_snap), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
